replay_bram: RTL and testbench
==============================

# replay_bram

- Single-clock, 512-entry block RAM that records one 144-bit snapshot per write of the pong game's object coordinates and replays it on read.
- Each snapshot holds twelve 12-bit fields: ball x1/x2/y1/y2, paddle B x1/x2/y1/y2, paddle B1 x1/x2/y1/y2.
- Sits between the pong game (writer) and the end-of-game replay renderer (reader).
- Infers a synchronous BRAM with a registered read port and a resettable output register.

## Interface
Parameters:
- RAM_WIDTH, 144, word width; must equal 12 × 12.
- RAM_ADDR_BITS, 9, address width; depth = 2^RAM_ADDR_BITS = 512.
- INIT_START_ADDR, 0, first entry zero-initialised at configuration.
- INIT_END_ADDR, 10, last entry zero-initialised at configuration (inclusive).

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  reset, asynchronous and active-low.
- ram_enable  in  1  enables any access.
- write_enable  in  1  1 = write, 0 = read (only when ram_enable = 1).
- address  in  RAM_ADDR_BITS  entry index.
- input_data, input_data1 … input_data11  in  12 each  write fields 0–11.
- output_data, output_data1 … output_data11  out  12 each  read fields 0–11.

## Operation
- Word packing: field k occupies bits [12k+11 : 12k].
  - input_data / output_data is field 0, bits [11:0].
  - input_data11 / output_data11 is field 11, bits [143:132].
- Write: ram_enable = 1 and write_enable = 1 → mem[address] ← packed {input_data11 … input_data} at the clock edge.
  - The output register holds its value during a write cycle.
- Read: ram_enable = 1 and write_enable = 0 → output register ← mem[address] at the clock edge.
  - The registered word is unpacked to output_data … output_data11.
- Idle: ram_enable = 0 → memory and output register both hold.
- Initialisation:
  - Entries INIT_START_ADDR..INIT_END_ADDR are 0 at configuration.
  - All other entries are also zero-initialised, so simulation and hardware agree.
  - Memory contents are not affected by reset_n.
- Reset: reset_n = 0 clears the output register to 0 immediately; all twelve outputs read 0.
- Address range: the full 9-bit range is valid. No wrap logic inside the block; the caller sequences addresses.
- Elaboration check: an error is raised if RAM_WIDTH ≠ 144, or if INIT_END_ADDR < INIT_START_ADDR or INIT_END_ADDR ≥ depth.

## Timing
- Write latency: 1 clock. Data written at edge N is readable by a read issued at edge N+1.
- Read latency: 1 clock. Address presented before edge N → data valid on the outputs after edge N and held until the next read or reset.
- Back-to-back reads: one word per cycle, no bubbles.
- Reset assertion is asynchronous; outputs go to 0 with no clock required.
- Reset release is synchronous: first access on the first rising edge with reset_n = 1.
- An edge with reset_n low performs no write.
- No read/write collision exists: there is a single port and write_enable selects the direction.

## Structure
- Shared package pong_pkg holds:
  - FIELD_W = 12, N_FIELDS = 12.
  - Field index constants: BALL_X1..BALL_Y2, PB_X1..PB_Y2, PB1_X1..PB1_Y2.
  - Pack/unpack functions for the 144-bit snapshot word.
- No sub-modules: one memory array plus one output register.
- Written in the inferable single-port BRAM template: registered output, no reset on the array.

## Test plan
- Reset: hold reset_n = 0 with random inputs and ram_enable = 1 → all outputs 0; after release, read address 5 → all fields 0 (initialised range).
- Write/read one entry:
  - Write address 3 with field k = 0x100 + k.
  - Read address 3 one cycle later.
  - Next cycle: output_data = 0x100 … output_data11 = 0x10B.
- Packing extremes:
  - Write address 511 with field 0 = 0xFFF, others 0, then read → only output_data = 0xFFF.
  - Write address 0 with field 11 = 0xABC → only output_data11 = 0xABC.
- Streaming:
  - Write addresses 0..511 with field k = (addr + k) mod 4096.
  - Read 0..511 back-to-back → each word matches, 1-cycle latency, no gaps.
- Hold behaviour:
  - After reading address 3, pulse a write to address 7 and set ram_enable = 0 for 5 cycles → outputs stay at address-3 data.
  - Then read address 7 → new data.
- Mid-operation reset:
  - Assert reset_n low asynchronously during a read stream → outputs 0 the same cycle.
  - After release, re-read address 3 → previously written data is intact.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared pong snapshot definitions: field layout, indices and pack/unpack helpers.
// Pure declarations, no timing; used by the game, the replay RAM and the renderer.
package pong_pkg;

    localparam int FIELD_W  = 12;
    localparam int N_FIELDS = 12;
    localparam int SNAP_W   = FIELD_W * N_FIELDS;

    localparam int BALL_X1 = 0;
    localparam int BALL_X2 = 1;
    localparam int BALL_Y1 = 2;
    localparam int BALL_Y2 = 3;
    localparam int PB_X1   = 4;
    localparam int PB_X2   = 5;
    localparam int PB_Y1   = 6;
    localparam int PB_Y2   = 7;
    localparam int PB1_X1  = 8;
    localparam int PB1_X2  = 9;
    localparam int PB1_Y1  = 10;
    localparam int PB1_Y2  = 11;

    typedef logic [FIELD_W-1:0] field_t;
    // Packed so that field k lands on bits [12k+11:12k] of the flat word.
    typedef field_t [N_FIELDS-1:0] snap_t;

    function automatic snap_t pack_snapshot(input field_t f [N_FIELDS]);
        snap_t w;
        w = '0;
        for (int k = 0; k < N_FIELDS; k++) begin
            w[k] = f[k];
        end
        return w;
    endfunction

    function automatic field_t unpack_field(input snap_t w, input int idx);
        return w[idx];
    endfunction

endpackage

// File: rtl/replay_bram.sv
// Single-port 512 x 144 replay RAM holding pong object snapshots, registered read port.
// 1-cycle write and read latency; no backpressure, one access per clock.
module replay_bram
    import pong_pkg::*;
#(
    parameter int RAM_WIDTH       = 144,
    parameter int RAM_ADDR_BITS   = 9,
    parameter int INIT_START_ADDR = 0,
    parameter int INIT_END_ADDR   = 10
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     ram_enable,
    input  logic                     write_enable,
    input  logic [RAM_ADDR_BITS-1:0] address,
    input  logic [FIELD_W-1:0]       input_data,
    input  logic [FIELD_W-1:0]       input_data1,
    input  logic [FIELD_W-1:0]       input_data2,
    input  logic [FIELD_W-1:0]       input_data3,
    input  logic [FIELD_W-1:0]       input_data4,
    input  logic [FIELD_W-1:0]       input_data5,
    input  logic [FIELD_W-1:0]       input_data6,
    input  logic [FIELD_W-1:0]       input_data7,
    input  logic [FIELD_W-1:0]       input_data8,
    input  logic [FIELD_W-1:0]       input_data9,
    input  logic [FIELD_W-1:0]       input_data10,
    input  logic [FIELD_W-1:0]       input_data11,
    output logic [FIELD_W-1:0]       output_data,
    output logic [FIELD_W-1:0]       output_data1,
    output logic [FIELD_W-1:0]       output_data2,
    output logic [FIELD_W-1:0]       output_data3,
    output logic [FIELD_W-1:0]       output_data4,
    output logic [FIELD_W-1:0]       output_data5,
    output logic [FIELD_W-1:0]       output_data6,
    output logic [FIELD_W-1:0]       output_data7,
    output logic [FIELD_W-1:0]       output_data8,
    output logic [FIELD_W-1:0]       output_data9,
    output logic [FIELD_W-1:0]       output_data10,
    output logic [FIELD_W-1:0]       output_data11
);

    localparam int DEPTH = 1 << RAM_ADDR_BITS;

    if (RAM_WIDTH != SNAP_W) begin : g_err_width
        $error("replay_bram: RAM_WIDTH must be 144 (twelve 12-bit fields)");
    end
    if (INIT_END_ADDR < INIT_START_ADDR) begin : g_err_init_order
        $error("replay_bram: INIT_END_ADDR precedes INIT_START_ADDR");
    end
    if (INIT_END_ADDR >= DEPTH) begin : g_err_init_range
        $error("replay_bram: INIT_END_ADDR beyond RAM depth");
    end

    // Whole array starts at zero, which covers the init window and keeps
    // simulation consistent with the configured device. Reset never touches it.
    logic [RAM_WIDTH-1:0] mem [DEPTH] = '{default: '0};

    field_t               in_f [N_FIELDS];
    snap_t                wr_word;
    logic                 wr_en;
    logic [RAM_WIDTH-1:0] rd_d;
    logic [RAM_WIDTH-1:0] rd_q;

    always_comb begin
        in_f[BALL_X1] = input_data;
        in_f[BALL_X2] = input_data1;
        in_f[BALL_Y1] = input_data2;
        in_f[BALL_Y2] = input_data3;
        in_f[PB_X1]   = input_data4;
        in_f[PB_X2]   = input_data5;
        in_f[PB_Y1]   = input_data6;
        in_f[PB_Y2]   = input_data7;
        in_f[PB1_X1]  = input_data8;
        in_f[PB1_X2]  = input_data9;
        in_f[PB1_Y1]  = input_data10;
        in_f[PB1_Y2]  = input_data11;
    end

    // Edges taken while reset is held must not commit a write.
    always_comb begin
        wr_word = pack_snapshot(in_f);
        wr_en   = ram_enable & write_enable & reset_n;
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[address] <= wr_word;
        end
    end

    always_comb begin
        rd_d = rd_q;
        if (ram_enable && !write_enable) begin
            rd_d = mem[address];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_d;
        end
    end

    assign output_data   = unpack_field(rd_q, BALL_X1);
    assign output_data1  = unpack_field(rd_q, BALL_X2);
    assign output_data2  = unpack_field(rd_q, BALL_Y1);
    assign output_data3  = unpack_field(rd_q, BALL_Y2);
    assign output_data4  = unpack_field(rd_q, PB_X1);
    assign output_data5  = unpack_field(rd_q, PB_X2);
    assign output_data6  = unpack_field(rd_q, PB_Y1);
    assign output_data7  = unpack_field(rd_q, PB_Y2);
    assign output_data8  = unpack_field(rd_q, PB1_X1);
    assign output_data9  = unpack_field(rd_q, PB1_X2);
    assign output_data10 = unpack_field(rd_q, PB1_Y1);
    assign output_data11 = unpack_field(rd_q, PB1_Y2);

endmodule

// File: tb/tb_replay_bram.sv
// Directed bench for replay_bram: reset, packing, streaming, hold and mid-stream reset.
module tb_replay_bram;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        ram_enable;
    logic        write_enable;
    logic [8:0]  address;
    logic [11:0] in_f  [12];
    logic [11:0] out_f [12];

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clock = ~clock;

    replay_bram dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .ram_enable   (ram_enable),
        .write_enable (write_enable),
        .address      (address),
        .input_data   (in_f[0]),
        .input_data1  (in_f[1]),
        .input_data2  (in_f[2]),
        .input_data3  (in_f[3]),
        .input_data4  (in_f[4]),
        .input_data5  (in_f[5]),
        .input_data6  (in_f[6]),
        .input_data7  (in_f[7]),
        .input_data8  (in_f[8]),
        .input_data9  (in_f[9]),
        .input_data10 (in_f[10]),
        .input_data11 (in_f[11]),
        .output_data  (out_f[0]),
        .output_data1 (out_f[1]),
        .output_data2 (out_f[2]),
        .output_data3 (out_f[3]),
        .output_data4 (out_f[4]),
        .output_data5 (out_f[5]),
        .output_data6 (out_f[6]),
        .output_data7 (out_f[7]),
        .output_data8 (out_f[8]),
        .output_data9 (out_f[9]),
        .output_data10(out_f[10]),
        .output_data11(out_f[11])
    );

    function automatic logic [143:0] out_word();
        logic [143:0] w;
        for (int k = 0; k < 12; k++) w[12*k +: 12] = out_f[k];
        return w;
    endfunction

    function automatic logic [143:0] stream_word(input int a);
        logic [143:0] w;
        for (int k = 0; k < 12; k++) w[12*k +: 12] = 12'(a + k);
        return w;
    endfunction

    function automatic logic [143:0] offset_word(input logic [11:0] base);
        logic [143:0] w;
        for (int k = 0; k < 12; k++) w[12*k +: 12] = base + 12'(k);
        return w;
    endfunction

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_write(input logic [8:0] a, input logic [143:0] w);
        ram_enable   = 1'b1;
        write_enable = 1'b1;
        address      = a;
        for (int k = 0; k < 12; k++) in_f[k] = w[12*k +: 12];
        cyc();
    endtask

    task automatic drive_read(input logic [8:0] a);
        ram_enable   = 1'b1;
        write_enable = 1'b0;
        address      = a;
        cyc();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ram_enable   = 1'b1;
            write_enable = 1'($urandom);
            address      = 9'($urandom);
            for (int k = 0; k < 12; k++) in_f[k] = 12'($urandom);
            cyc();
            n_checks++;
            if (out_word() !== 144'h0) begin
                n_fails++;
                $display("FAIL reset_hold cyc%0d: got %h expected 0", i, out_word());
            end
        end
        reset_n = 1'b1;
        drive_read(9'd5);
        n_checks++;
        if (out_word() !== 144'h0) begin
            n_fails++;
            $display("FAIL reset_init_read5: got %h expected 0", out_word());
        end
    endtask

    task automatic test_write_read();
        logic [143:0] w;
        w = offset_word(12'h100);
        drive_write(9'd3, w);
        drive_read(9'd3);
        n_checks++;
        if (out_word() !== w) begin
            n_fails++;
            $display("FAIL wr_rd_addr3: got %h expected %h", out_word(), w);
        end
        n_checks++;
        if (out_f[0] !== 12'h100 || out_f[11] !== 12'h10B) begin
            n_fails++;
            $display("FAIL wr_rd_fields: got f0=%h f11=%h expected 100/10B", out_f[0], out_f[11]);
        end
    endtask

    task automatic test_packing_extremes();
        logic [143:0] w_lo;
        logic [143:0] w_hi;
        w_lo = '0;
        w_lo[11:0] = 12'hFFF;
        w_hi = '0;
        w_hi[143:132] = 12'hABC;
        drive_write(9'd511, w_lo);
        drive_write(9'd0, w_hi);
        drive_read(9'd511);
        n_checks++;
        if (out_word() !== w_lo || out_f[0] !== 12'hFFF) begin
            n_fails++;
            $display("FAIL pack_field0_addr511: got %h expected %h", out_word(), w_lo);
        end
        drive_read(9'd0);
        n_checks++;
        if (out_word() !== w_hi || out_f[11] !== 12'hABC) begin
            n_fails++;
            $display("FAIL pack_field11_addr0: got %h expected %h", out_word(), w_hi);
        end
    endtask

    task automatic test_back_to_back();
        for (int a = 0; a < 512; a++) drive_write(9'(a), stream_word(a));
        ram_enable   = 1'b1;
        write_enable = 1'b0;
        address      = 9'd0;
        cyc();
        for (int i = 0; i < 512; i++) begin
            n_checks++;
            if (out_word() !== stream_word(i)) begin
                n_fails++;
                $display("FAIL stream_addr%0d: got %h expected %h", i, out_word(), stream_word(i));
            end
            if (i < 511) begin
                address = 9'(i + 1);
                cyc();
            end
        end
    endtask

    task automatic test_hold();
        logic [143:0] w7;
        w7 = offset_word(12'hA00);
        drive_read(9'd3);
        n_checks++;
        if (out_word() !== stream_word(3)) begin
            n_fails++;
            $display("FAIL hold_read3: got %h expected %h", out_word(), stream_word(3));
        end
        drive_write(9'd7, w7);
        n_checks++;
        if (out_word() !== stream_word(3)) begin
            n_fails++;
            $display("FAIL hold_during_write: got %h expected %h", out_word(), stream_word(3));
        end
        // Idle cycles carry a would-be write that must be ignored.
        ram_enable   = 1'b0;
        write_enable = 1'b1;
        address      = 9'd7;
        for (int k = 0; k < 12; k++) in_f[k] = 12'h555;
        for (int i = 0; i < 5; i++) begin
            cyc();
            n_checks++;
            if (out_word() !== stream_word(3)) begin
                n_fails++;
                $display("FAIL hold_idle cyc%0d: got %h expected %h", i, out_word(), stream_word(3));
            end
        end
        drive_read(9'd7);
        n_checks++;
        if (out_word() !== w7) begin
            n_fails++;
            $display("FAIL hold_read7: got %h expected %h", out_word(), w7);
        end
    endtask

    task automatic test_mid_reset();
        drive_read(9'd20);
        drive_read(9'd21);
        n_checks++;
        if (out_word() !== stream_word(21)) begin
            n_fails++;
            $display("FAIL midrst_pre: got %h expected %h", out_word(), stream_word(21));
        end
        address = 9'd22;
        #3;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (out_word() !== 144'h0) begin
            n_fails++;
            $display("FAIL midrst_async_clear: got %h expected 0", out_word());
        end
        // An edge under reset with a write request must leave memory alone.
        write_enable = 1'b1;
        address      = 9'd3;
        for (int k = 0; k < 12; k++) in_f[k] = 12'hEEE;
        cyc();
        n_checks++;
        if (out_word() !== 144'h0) begin
            n_fails++;
            $display("FAIL midrst_held: got %h expected 0", out_word());
        end
        write_enable = 1'b0;
        reset_n      = 1'b1;
        cyc();
        n_checks++;
        if (out_word() !== stream_word(3)) begin
            n_fails++;
            $display("FAIL midrst_reread3: got %h expected %h", out_word(), stream_word(3));
        end
    endtask

    initial begin
        reset_n      = 1'b0;
        ram_enable   = 1'b0;
        write_enable = 1'b0;
        address      = '0;
        for (int k = 0; k < 12; k++) in_f[k] = '0;
        test_reset();
        test_write_read();
        test_packing_extremes();
        test_back_to_back();
        test_hold();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
